// File: rtl/layer_output_serializer.sv
// Captures one layer's parallel outputs in a single cycle and streams them one word per handshake.
// Latency: word 0 is valid the cycle after capture; i_ready throttles the stream; o_valid is never withdrawn.
module layer_output_serializer #(
  parameter int LAYER_ID   = 1,
  parameter int NUM_NEURON = 30,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_layer_data,
  input  logic                             i_layer_valid,
  output logic                             o_layer_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [31:0]                      o_neuron_id,
  output logic [31:0]                      o_layer_id,
  output logic                             o_last,
  output logic                             o_done
);

  localparam int IW = $clog2(NUM_NEURON);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURON - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] buf_q [NUM_NEURON];
  logic                  capture;
  logic                  handshake;
  logic                  at_last;

  assign at_last   = (idx_q == LAST_IDX);
  assign handshake = (state_q == SEND) && i_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_layer_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (at_last) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Buffer only loads in IDLE, so a mid-stream i_layer_valid cannot disturb the words in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_NEURON; k++) buf_q[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_NEURON; k++) buf_q[k] <= i_layer_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // All stream outputs decode from registers, so a downstream ready derived from them forms no loop.
  assign o_layer_ready = (state_q == IDLE);
  assign o_valid       = (state_q == SEND);
  assign o_data        = (state_q == SEND) ? buf_q[idx_q] : '0;
  assign o_neuron_id   = (state_q == SEND) ? {{(32-IW){1'b0}}, idx_q} : 32'd0;
  assign o_layer_id    = (state_q == SEND) ? 32'(LAYER_ID) : 32'd0;
  assign o_last        = (state_q == SEND) && at_last;
  assign o_done        = done_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed table-driven bench for layer_output_serializer with 4 neurons of 8 bits.
module tb_layer_output_serializer;

  localparam int NN = 4;
  localparam int DW = 8;
  localparam logic [NN*DW-1:0] LA = 32'h44332211;
  localparam logic [NN*DW-1:0] LB = 32'hDDCCBBAA;

  logic             clk;
  logic             rst_n;
  logic [NN*DW-1:0] layer_data;
  logic             layer_valid;
  logic             layer_ready;
  logic [DW-1:0]    data;
  logic             valid;
  logic             ready;
  logic [31:0]      neuron_id;
  logic [31:0]      layer_id;
  logic             last;
  logic             done;

  int checks = 0;
  int errors = 0;

  layer_output_serializer #(.LAYER_ID(1), .NUM_NEURON(NN), .DATA_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_layer_data (layer_data),
    .i_layer_valid(layer_valid),
    .o_layer_ready(layer_ready),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_neuron_id  (neuron_id),
    .o_layer_id   (layer_id),
    .o_last       (last),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             lv;
    logic [NN*DW-1:0] ld;
    logic             rdy;
    logic             ev;
    logic [DW-1:0]    ed;
    logic [31:0]      enid;
    logic             elast;
    logic             edone;
  } vec_t;

  vec_t vecs [32];

  task automatic setv(input int i, input logic lv, input logic [NN*DW-1:0] ld, input logic rdy,
                      input logic ev, input logic [DW-1:0] ed, input int enid,
                      input logic elast, input logic edone);
    vecs[i].lv = lv;    vecs[i].ld = ld;       vecs[i].rdy = rdy;
    vecs[i].ev = ev;    vecs[i].ed = ed;       vecs[i].enid = enid;
    vecs[i].elast = elast; vecs[i].edone = edone;
  endtask

  // Compares every output against the expectation; o_data only matters while valid.
  task automatic check_out(input string name, input logic ev, input logic [DW-1:0] ed,
                           input logic [31:0] enid, input logic elast, input logic edone);
    logic        elr;
    logic [31:0] elid;
    logic        ok;
    elr  = !ev;
    elid = ev ? 32'd1 : 32'd0;
    ok = (valid === ev) && (layer_ready === elr) && (neuron_id === enid) &&
         (layer_id === elid) && (last === elast) && (done === edone) &&
         (!ev || data === ed);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got v=%b lr=%b d=%h nid=%0d lid=%0d last=%b done=%b, want v=%b lr=%b d=%h nid=%0d lid=%0d last=%b done=%b",
               name, valid, layer_ready, data, neuron_id, layer_id, last, done,
               ev, elr, ed, enid, elid, elast, edone);
    end
  endtask

  task automatic run_vec(input int i);
    layer_valid = vecs[i].lv;
    layer_data  = vecs[i].ld;
    ready       = vecs[i].rdy;
    @(posedge clk);
    #1;
    check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].enid, vecs[i].elast, vecs[i].edone);
  endtask

  initial begin
    rst_n = 1'b1;
    layer_valid = 1'b0;
    layer_data = '0;
    ready = 1'b0;

    // idle / full-rate stream
    setv(0,  0, '0, 1, 0, 8'h00, 0, 0, 0);
    setv(1,  0, '0, 0, 0, 8'h00, 0, 0, 0);
    setv(2,  1, LA, 0, 1, 8'h11, 0, 0, 0);
    setv(3,  0, '0, 1, 1, 8'h22, 1, 0, 0);
    setv(4,  0, '0, 1, 1, 8'h33, 2, 0, 0);
    setv(5,  0, '0, 1, 1, 8'h44, 3, 1, 0);
    setv(6,  0, '0, 1, 0, 8'h00, 0, 0, 1);
    setv(7,  0, '0, 0, 0, 8'h00, 0, 0, 0);
    // back-pressure 1,0,0,1,1,0,1 with capture attempts mid-stream
    setv(8,  1, LA, 0, 1, 8'h11, 0, 0, 0);
    setv(9,  0, '0, 1, 1, 8'h22, 1, 0, 0);
    setv(10, 1, LB, 0, 1, 8'h22, 1, 0, 0);
    setv(11, 0, '0, 0, 1, 8'h22, 1, 0, 0);
    setv(12, 1, LB, 1, 1, 8'h33, 2, 0, 0);
    setv(13, 1, LB, 1, 1, 8'h44, 3, 1, 0);
    setv(14, 0, '0, 0, 1, 8'h44, 3, 1, 0);
    setv(15, 0, '0, 1, 0, 8'h00, 0, 0, 1);
    // back-to-back layers with valid held high
    setv(16, 1, LB, 1, 1, 8'hAA, 0, 0, 0);
    setv(17, 1, LB, 1, 1, 8'hBB, 1, 0, 0);
    setv(18, 1, LB, 1, 1, 8'hCC, 2, 0, 0);
    setv(19, 1, LB, 1, 1, 8'hDD, 3, 1, 0);
    setv(20, 1, LA, 1, 0, 8'h00, 0, 0, 1);
    setv(21, 1, LA, 1, 1, 8'h11, 0, 0, 0);
    setv(22, 0, '0, 1, 1, 8'h22, 1, 0, 0);
    setv(23, 0, '0, 1, 1, 8'h33, 2, 0, 0);
    // fresh capture after the mid-stream reset
    setv(24, 1, LB, 0, 1, 8'hAA, 0, 0, 0);
    setv(25, 0, '0, 1, 1, 8'hBB, 1, 0, 0);
    setv(26, 0, '0, 1, 1, 8'hCC, 2, 0, 0);

    #1 rst_n = 1'b0;
    #1 check_out("reset_async", 0, 8'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check_out("reset_held", 0, 8'h00, 0, 0, 0);
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", data);
    end
    checks++;
    #2 rst_n = 1'b1;

    for (int i = 0; i < 24; i++) run_vec(i);

    // vec23 left the stream at index 2; reset between edges must clear immediately
    #2 rst_n = 1'b0;
    #1 check_out("reset_mid_imm", 0, 8'h00, 0, 0, 0);
    ready = 1'b1;
    @(posedge clk);
    #1 check_out("reset_mid_hold", 0, 8'h00, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 24; i < 27; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/layer_output_serializer.md
# layer_output_serializer

Captures the parallel outputs of one fully-connected layer (NUM_NEURON words) in a single cycle and streams them one word per handshake to the next layer. Sits directly upstream of the next layer's ready-select mux: it drives the neuron index and layer ID that the mux uses to pick the back-pressure bit, and consumes the selected ready as its stream ready.

## Interface
- LAYER_ID, 1: ID driven on o_layer_id while streaming; 0 is reserved for "no layer".
- NUM_NEURON, 30: number of words per layer output; must be ≥ 2.
- DATA_WIDTH, 16: width of each neuron output word.
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_layer_data  input  NUM_NEURON*DATA_WIDTH  packed layer outputs; word k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_layer_valid  input  1  all words of i_layer_data are valid.
- o_layer_ready  output  1  serializer can capture a layer.
- o_data  output  DATA_WIDTH  current stream word.
- o_valid  output  1  o_data is valid.
- i_ready  input  1  downstream ready; this is the mux's o_ready.
- o_neuron_id  output  32  index of the word on o_data; feeds the mux's i_neuron_id.
- o_layer_id  output  32  LAYER_ID while streaming, else 0; feeds the mux's i_layer_id.
- o_last  output  1  high with the final word (index NUM_NEURON-1).
- o_done  output  1  one-cycle pulse after the final handshake.

## Operation
- Two states: IDLE and SEND.
- IDLE:
  - Outputs: o_layer_ready=1, o_valid=0, o_layer_id=0, o_neuron_id=0, o_last=0.
  - On i_layer_valid=1 (capture handshake):
    - Register all NUM_NEURON words into an internal buffer.
    - Set index=0 and go to SEND.
- SEND:
  - Outputs: o_layer_ready=0, o_valid=1, o_layer_id=LAYER_ID, o_neuron_id=index.
  - o_data=buffer[index], selected from registers only, with no input-to-output combinational path.
  - o_last=1 when index==NUM_NEURON-1.
  - The stream handshake is o_valid && i_ready in the same cycle.
  - On a handshake with index<NUM_NEURON-1: index increments.
  - On a handshake with index==NUM_NEURON-1: return to IDLE, index goes to 0, and o_done pulses high for the next cycle.
  - Without a handshake, o_data, o_neuron_id and o_last hold stable; o_valid is never withdrawn.
- i_layer_valid and i_layer_data are ignored in SEND. The buffer is not overwritten mid-stream.
- Index counter width is $clog2(NUM_NEURON), zero-extended to 32 bits on o_neuron_id.
- i_ready is sampled only in SEND. Its value in IDLE has no effect.

## Timing
- Reset (i_rst_n=0, asynchronous, any state):
  - State goes to IDLE; buffer and index clear to 0.
  - Outputs: o_layer_ready=1, o_valid=0, o_data=0, o_neuron_id=0, o_layer_id=0, o_last=0, o_done=0.
  - A stream interrupted by reset is abandoned. No partial resume.
- Capture latency: i_layer_valid is sampled at edge N; o_valid=1 with word 0 from the cycle after edge N.
- Throughput: one word per cycle when i_ready is held high. A full layer takes NUM_NEURON cycles in SEND.
- Turnaround: after the final handshake there is one IDLE cycle, concurrent with o_done=1, before the next capture can occur. A minimum period of NUM_NEURON+1 cycles per layer with constant ready.
- Circular dependency: o_neuron_id and o_layer_id are registered state. The downstream i_ready may depend on them combinationally without forming a loop.
- o_layer_id returns to 0 in the IDLE cycle, so the downstream mux drives ready=0 there.

## Test plan
- Reset/idle (NUM_NEURON=4, DATA_WIDTH=8): hold i_rst_n=0, then release → all outputs at reset values, o_layer_ready=1; i_ready toggling in IDLE causes no change.
- Full-rate stream: capture words {0x11,0x22,0x33,0x44} with i_ready=1 → o_data 0x11,0x22,0x33,0x44 on four consecutive cycles, o_neuron_id 0..3, o_layer_id=1, o_last only with 0x44, o_done pulse on the next cycle.
- Back-pressure: pattern i_ready=1,0,0,1,1,0,1 → each word and ID held stable while i_ready=0, no word skipped or duplicated, exactly 4 handshakes.
- Capture ignored while busy: change i_layer_data and pulse i_layer_valid mid-stream → streamed words remain the originally captured values.
- Back-to-back layers: i_layer_valid held high and i_ready=1 → second layer's word 0 appears 2 cycles after the first layer's last handshake, with one IDLE gap where o_valid=0 and o_layer_id=0.
- Async reset mid-stream: assert i_rst_n=0 between clock edges at index 2 → outputs return to reset values immediately; a fresh capture restarts at index 0.
